// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Carry,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       IR_write,
  output logic       Adr_src,
  output logic       mem_req,
  output logic       Mem_Write,
  output logic       Reg_Write,
  output logic [1:0] ALU_srcA,
  output logic [1:0] ALU_srcB,
  output logic [1:0] ALU_op,
  output logic [1:0] Result_src,
  output logic [2:0] Imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_LINK     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q;
  state_t state_d;
  logic   taken;

  // funct3[1] does not distinguish the supported branch conditions
  logic unused_funct3_b1;
  assign unused_funct3_b1 = funct3[1];

  assign state = state_q;

  // State register; reset abandons any access and returns to FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; everything is masked to 0 while reset is held
  always_comb begin
    state_d    = state_q;
    PC_write   = 1'b0;
    IR_write   = 1'b0;
    Adr_src    = 1'b0;
    mem_req    = 1'b0;
    Mem_Write  = 1'b0;
    Reg_Write  = 1'b0;
    ALU_srcA   = 2'b00;
    ALU_srcB   = 2'b00;
    ALU_op     = 2'b00;
    Result_src = 2'b00;
    Imm_src    = 3'b000;
    illegal    = 1'b0;

    case ({funct3[2], funct3[0]})
      2'b00:   taken = Zero;
      2'b01:   taken = ~Zero;
      2'b10:   taken = Carry;
      default: taken = ~Carry;
    endcase

    case (opcode)
      OP_STORE:        Imm_src = 3'b001;
      OP_BRANCH:       Imm_src = 3'b010;
      OP_JAL:          Imm_src = 3'b011;
      OP_LUI, OP_AUIPC: Imm_src = 3'b100;
      default:         Imm_src = 3'b000;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        ALU_srcB   = 2'b10;
        Result_src = 2'b10;
        if (mem_ready) begin
          IR_write = 1'b1;
          PC_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_srcA = 2'b01;
        ALU_srcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALU_srcA = 2'b10;
        ALU_srcB = 2'b01;
        // only loads and stores reach here; opcode bit 5 separates them
        state_d  = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        Adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        Result_src = 2'b01;
        Reg_Write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        Mem_Write = 1'b1;
        Adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_srcA = 2'b10;
        ALU_op   = 2'b10;
        state_d  = S_ALUWB;
      end
      S_EXEC_I: begin
        ALU_srcA = 2'b10;
        ALU_srcB = 2'b01;
        ALU_op   = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        Reg_Write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALU_srcA = 2'b10;
        ALU_op   = 2'b01;
        PC_write = taken;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        PC_write = 1'b1;
        ALU_srcA = 2'b01;
        ALU_srcB = 2'b10;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        ALU_srcA   = 2'b10;
        ALU_srcB   = 2'b01;
        Result_src = 2'b10;
        PC_write   = 1'b1;
        state_d    = S_LINK;
      end
      S_LINK: begin
        ALU_srcA = 2'b01;
        ALU_srcB = 2'b10;
        state_d  = S_ALUWB;
      end
      S_LUI: begin
        Result_src = 2'b11;
        Reg_Write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_AUIPC: begin
        ALU_srcA = 2'b01;
        ALU_srcB = 2'b01;
        state_d  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      PC_write   = 1'b0;
      IR_write   = 1'b0;
      Adr_src    = 1'b0;
      mem_req    = 1'b0;
      Mem_Write  = 1'b0;
      Reg_Write  = 1'b0;
      ALU_srcA   = 2'b00;
      ALU_srcB   = 2'b00;
      ALU_op     = 2'b00;
      Result_src = 2'b00;
      Imm_src    = 3'b000;
      illegal    = 1'b0;
    end
  end

endmodule
